// File: rtl/pinky_writeback.sv
// PinKY stage 3: retires stage-2 results into the register file, owns the Z flag,
// redirects fetch on R15 writes, squashes wrong-path work and latches halt on SYS.
// Optional same-cycle forwarding ports are enabled with `define WB_BYPASS_EN.
module pinky_writeback #(
  parameter int SQUASH_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [6:0]  op_cc_in,
  input  logic [3:0]  dest_in,
  input  logic [15:0] value_in,
  input  logic [15:0] pc_in,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        z_flag,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        squash,
  output logic        halt,
  output logic [15:0] retired,
  output logic [15:0] last_pc
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_valid,
  output logic [3:0]  byp_addr,
  output logic [15:0] byp_data
`endif
);

  localparam logic [4:0] OP_SYS  = 5'h13;
  localparam logic [1:0] CC_S    = 2'd1;
  localparam logic [3:0] REG_PC  = 4'd15;
  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

  logic [4:0]  opcode;
  logic [1:0]  cc;
  logic        is_write;
  logic        accept;

  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        z_q, z_d;
  logic        redirect_q, redirect_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;
  logic [2:0]  sq_cnt_q, sq_cnt_d;
  logic        halt_q, halt_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] last_pc_q, last_pc_d;

  assign opcode   = op_cc_in[6:2];
  assign cc       = op_cc_in[1:0];
  // Write class: 0x00-0x0E and 0x10-0x12; STR, SYS, NOP, reserved and PRE never write.
  assign is_write = (opcode <= 5'h0E) || ((opcode >= 5'h10) && (opcode <= 5'h12));
  assign accept   = valid_in && (sq_cnt_q == 3'd0) && !halt_q;

  always_comb begin
    wr_en_d       = accept && is_write;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    z_d           = z_q;
    redirect_d    = accept && is_write && (dest_in == REG_PC);
    redirect_pc_d = redirect_pc_q;
    sq_cnt_d      = sq_cnt_q;
    halt_d        = halt_q || (accept && (opcode == OP_SYS));
    retired_d     = retired_q;
    last_pc_d     = last_pc_q;

    if (accept) begin
      retired_d = retired_q + 16'd1;
      last_pc_d = pc_in;
    end
    if (wr_en_d) begin
      wr_addr_d = dest_in;
      wr_data_d = value_in;
      if (cc == CC_S) z_d = (value_in == 16'h0000);
    end
    if (redirect_d) redirect_pc_d = value_in;

    // Only valid slots consume the squash window; bubbles leave it untouched.
    if (redirect_d)
      sq_cnt_d = SQ_LOAD;
    else if (valid_in && (sq_cnt_q != 3'd0))
      sq_cnt_d = sq_cnt_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 4'd0;
      wr_data_q     <= 16'd0;
      z_q           <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 16'd0;
      sq_cnt_q      <= 3'd0;
      halt_q        <= 1'b0;
      retired_q     <= 16'd0;
      last_pc_q     <= 16'd0;
    end else begin
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      z_q           <= z_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      sq_cnt_q      <= sq_cnt_d;
      halt_q        <= halt_d;
      retired_q     <= retired_d;
      last_pc_q     <= last_pc_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign z_flag      = z_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign squash      = (sq_cnt_q != 3'd0);
  assign halt        = halt_q;
  assign retired     = retired_q;
  assign last_pc     = last_pc_q;

`ifdef WB_BYPASS_EN
  // Same qualification as the write strobe, but from the live inputs.
  assign byp_valid = reset && accept && is_write;
  assign byp_addr  = dest_in;
  assign byp_data  = value_in;
`endif

endmodule
